// File: rtl/mem_rdwr_fsm.sv
// Single-shot Avalon-MM burst engine between the CSR block and one local-memory bank.
// Runs one read or write burst per software command and reports done/status/errors.
module mem_rdwr_fsm #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 512,
  parameter int BURST_W = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                SoftReset_n,
  input  logic                cmd_read,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [BURST_W-1:0]  cmd_burstcount,
  input  logic [DATA_W-1:0]   cmd_writedata,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  input  logic                rdwr_reset,
  input  logic                mem_error_clr,
  output logic                ready_for_sw_cmd,
  output logic [1:0]          rdwr_done,
  output logic [4:0]          rdwr_status,
  output logic [2:0]          fsm_state,
  output logic [31:0]         mem_errors,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [BURST_W-1:0]  mem_burstcount,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic                mem_readdatavalid,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic [1:0]          mem_response
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

  state_t               r_state, w_next;
  logic                 r_rd_q, r_wr_q;
  logic [BURST_W-1:0]   r_beats;
  logic [15:0]          r_stall;
  logic                 r_rd_err;
  logic [1:0]           r_done;
  logic [4:0]           r_status;
  logic [31:0]          r_errs;
  logic [DATA_W-1:0]    r_rd_data;
  logic [ADDR_W-1:0]    r_addr;
  logic [BURST_W-1:0]   r_bc;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W/8-1:0]  r_be;

  logic w_rd_rise, w_wr_rise, w_last, w_stall_max;
  logic w_acc_wr, w_acc_rd, w_illegal, w_stall;
  logic w_wr_beat, w_rd_beat, w_wr_fin, w_rd_fin, w_wr_to, w_rd_to, w_rd_err;
  logic [BURST_W-1:0] w_bc;

  assign w_rd_rise   = cmd_read  & ~r_rd_q;
  assign w_wr_rise   = cmd_write & ~r_wr_q;
  assign w_last      = (r_beats == BURST_W'(1));
  assign w_stall_max = (r_stall == STALL_MAX);
  assign w_bc        = (cmd_burstcount == '0) ? BURST_W'(1) : cmd_burstcount;
  assign w_rd_err    = w_rd_beat & (mem_response != 2'b00);

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_acc_wr  = 1'b0;
    w_acc_rd  = 1'b0;
    w_illegal = 1'b0;
    w_stall   = 1'b0;
    w_wr_beat = 1'b0;
    w_rd_beat = 1'b0;
    w_wr_fin  = 1'b0;
    w_rd_fin  = 1'b0;
    w_wr_to   = 1'b0;
    w_rd_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_rise && w_wr_rise) w_illegal = 1'b1;
        else if (w_wr_rise) begin w_acc_wr = 1'b1; w_next = S_WR; end
        else if (w_rd_rise) begin w_acc_rd = 1'b1; w_next = S_RD_REQ; end
      end
      S_WR: begin
        if (!mem_waitrequest) begin
          w_wr_beat = 1'b1;
          if (w_last) begin w_wr_fin = 1'b1; w_next = S_DONE; end
        end else begin
          w_stall = 1'b1;
          if (w_stall_max) begin w_wr_to = 1'b1; w_next = S_DONE; end
        end
      end
      S_RD_REQ: begin
        if (!mem_waitrequest) w_next = S_RD_WAIT;
        else begin
          w_stall = 1'b1;
          if (w_stall_max) begin w_rd_to = 1'b1; w_next = S_DONE; end
        end
      end
      S_RD_WAIT: begin
        if (mem_readdatavalid) begin
          w_rd_beat = 1'b1;
          if (w_last) begin w_rd_fin = 1'b1; w_next = S_DONE; end
        end else begin
          w_stall = 1'b1;
          if (w_stall_max) begin w_rd_to = 1'b1; w_next = S_DONE; end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Any fresh strobe outside IDLE is dropped and flagged.
    if (r_state != S_IDLE && (w_rd_rise || w_wr_rise)) w_illegal = 1'b1;
  end

  // Strobe history resets high so a strobe held across reset release is not an edge.
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_rd_q <= 1'b1;
      r_wr_q <= 1'b1;
    end else begin
      r_rd_q <= cmd_read;
      r_wr_q <= cmd_write;
    end
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_beats   <= '0;
      r_stall   <= '0;
      r_rd_err  <= 1'b0;
      r_rd_data <= '0;
      r_addr    <= '0;
      r_bc      <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else begin
      if (w_acc_wr || w_acc_rd) begin
        r_addr  <= cmd_address;
        r_bc    <= w_bc;
        r_beats <= w_bc;
        r_wdata <= cmd_writedata;
        r_be    <= cmd_byteenable;
      end else if (w_wr_beat || w_rd_beat) begin
        r_beats <= r_beats - BURST_W'(1);
      end
      if (w_next != r_state) r_stall <= '0;
      else if (w_stall)      r_stall <= r_stall + 16'd1;
      else                   r_stall <= '0;
      if (w_acc_rd)      r_rd_err <= 1'b0;
      else if (w_rd_err) r_rd_err <= 1'b1;
      if (w_rd_beat) r_rd_data <= mem_readdata;
    end
  end

  // Clear first so a same-cycle set event overrides it.
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_done   <= '0;
      r_status <= '0;
      r_errs   <= '0;
    end else begin
      if (rdwr_reset) begin
        r_done   <= '0;
        r_status <= '0;
      end
      if (w_illegal) r_status[4] <= 1'b1;
      if (w_wr_fin) begin r_done[0] <= 1'b1; r_status[1:0] <= 2'b00; end
      if (w_wr_to)  begin r_done[0] <= 1'b1; r_status[1:0] <= 2'b01; end
      if (w_rd_err) r_status[3:2] <= 2'b01;
      if (w_rd_fin) begin
        r_done[1]     <= 1'b1;
        r_status[3:2] <= (r_rd_err || w_rd_err) ? 2'b01 : 2'b00;
      end
      if (w_rd_to)  begin r_done[1] <= 1'b1; r_status[3:2] <= 2'b10; end
      if (mem_error_clr)                 r_errs <= '0;
      else if (w_rd_err && r_errs != '1) r_errs <= r_errs + 32'd1;
    end
  end

  assign ready_for_sw_cmd = (r_state == S_IDLE);
  assign fsm_state        = r_state;
  assign rdwr_done        = r_done;
  assign rdwr_status      = r_status;
  assign mem_errors       = r_errs;
  assign rd_data          = r_rd_data;
  assign mem_address      = r_addr;
  assign mem_burstcount   = r_bc;
  assign mem_writedata    = r_wdata;
  assign mem_byteenable   = r_be;
  assign mem_write        = (r_state == S_WR);
  assign mem_read         = (r_state == S_RD_REQ);

endmodule

// File: tb/tb_mem_rdwr_fsm.sv
// Directed bench for mem_rdwr_fsm: write/read bursts, stalls, errors, timeout,
// illegal strobes, clear/set races and asynchronous reset.
module tb_mem_rdwr_fsm;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 512;
  localparam int BURST_W = 7;
  localparam int TO      = 16;

  logic                clk;
  logic                SoftReset_n;
  logic                cmd_read, cmd_write;
  logic [ADDR_W-1:0]   cmd_address;
  logic [BURST_W-1:0]  cmd_burstcount;
  logic [DATA_W-1:0]   cmd_writedata;
  logic [DATA_W/8-1:0] cmd_byteenable;
  logic                rdwr_reset, mem_error_clr;
  logic                ready_for_sw_cmd;
  logic [1:0]          rdwr_done;
  logic [4:0]          rdwr_status;
  logic [2:0]          fsm_state;
  logic [31:0]         mem_errors;
  logic [DATA_W-1:0]   rd_data;
  logic [ADDR_W-1:0]   mem_address;
  logic [BURST_W-1:0]  mem_burstcount;
  logic                mem_read, mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_waitrequest, mem_readdatavalid;
  logic [DATA_W-1:0]   mem_readdata;
  logic [1:0]          mem_response;

  int checks = 0;
  int errors = 0;

  mem_rdwr_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TIMEOUT(TO)) dut (
    .clk(clk), .SoftReset_n(SoftReset_n),
    .cmd_read(cmd_read), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
    .cmd_writedata(cmd_writedata), .cmd_byteenable(cmd_byteenable),
    .rdwr_reset(rdwr_reset), .mem_error_clr(mem_error_clr),
    .ready_for_sw_cmd(ready_for_sw_cmd), .rdwr_done(rdwr_done),
    .rdwr_status(rdwr_status), .fsm_state(fsm_state), .mem_errors(mem_errors),
    .rd_data(rd_data), .mem_address(mem_address), .mem_burstcount(mem_burstcount),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata),
    .mem_response(mem_response)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rdwr_reset();
    rdwr_reset = 1'b1;
    tick();
    rdwr_reset = 1'b0;
  endtask

  initial begin
    int wcnt, rcnt, hit;
    SoftReset_n = 1'b0;
    cmd_read = 1'b0; cmd_write = 1'b0;
    cmd_address = '0; cmd_burstcount = '0; cmd_writedata = '0; cmd_byteenable = '0;
    rdwr_reset = 1'b0; mem_error_clr = 1'b0;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0; mem_response = 2'b00;

    repeat (2) tick();
    chk("rst_ready", 64'(ready_for_sw_cmd), 64'd1);
    chk("rst_state", 64'(fsm_state), 64'd0);
    chk("rst_wr_rd", 64'({mem_write, mem_read}), 64'd0);
    chk("rst_done_status", 64'({rdwr_done, rdwr_status}), 64'd0);
    chk("rst_errors", 64'(mem_errors), 64'd0);
    chk("rst_rd_data", rd_data[63:0], 64'd0);
    chk("rst_addr_bc", 64'({mem_address, mem_burstcount}), 64'd0);
    SoftReset_n = 1'b1;
    tick();

    // Write, 4 beats, no waitrequest
    cmd_write = 1'b1; cmd_address = 26'h100; cmd_burstcount = 7'd4;
    cmd_writedata = 512'hDEAD_BEEF; cmd_byteenable = '1;
    wcnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin
        cmd_write = 1'b0;
        chk("wr1_ready_low", 64'(ready_for_sw_cmd), 64'd0);
        chk("wr1_addr", 64'(mem_address), 64'h100);
        chk("wr1_bc", 64'(mem_burstcount), 64'd4);
        chk("wr1_wdata", mem_writedata[63:0], 64'hDEAD_BEEF);
        chk("wr1_be_top", 64'(mem_byteenable[63]), 64'd1);
      end
      wcnt += int'(mem_write);
      if (i == 5) begin
        chk("wr1_done_state", 64'(fsm_state), 64'd4);
        chk("wr1_done", 64'(rdwr_done), 64'b01);
        chk("wr1_ready_in_done", 64'(ready_for_sw_cmd), 64'd0);
      end
      if (i == 6) chk("wr1_ready_again", 64'(ready_for_sw_cmd), 64'd1);
    end
    chk("wr1_beats", 64'(wcnt), 64'd4);
    chk("wr1_status", 64'(rdwr_status), 64'd0);

    pulse_rdwr_reset();
    chk("rdwr_reset_clears", 64'(rdwr_done), 64'd0);

    // Write, 2 beats, waitrequest high for the first 3 cycles
    cmd_write = 1'b1; cmd_address = 26'h200; cmd_burstcount = 7'd2;
    cmd_writedata = 512'h1234_5678; mem_waitrequest = 1'b1;
    wcnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) cmd_write = 1'b0;
      wcnt += int'(mem_write);
      if (mem_write) begin
        chk("wr2_addr_stable", 64'({mem_address, mem_burstcount}), 64'({26'h200, 7'd2}));
        chk("wr2_data_stable", mem_writedata[63:0], 64'h1234_5678);
      end
      if (i == 4) mem_waitrequest = 1'b0;
    end
    chk("wr2_write_cycles", 64'(wcnt), 64'd5);
    chk("wr2_done", 64'(rdwr_done), 64'b01);
    chk("wr2_idle", 64'(fsm_state), 64'd0);

    // Read, 3 beats, second beat errors
    cmd_read = 1'b1; cmd_address = 26'h300; cmd_burstcount = 7'd3;
    tick();
    cmd_read = 1'b0;
    chk("rd_req", 64'({mem_read, fsm_state}), 64'({1'b1, 3'd2}));
    chk("rd_req_bc", 64'(mem_burstcount), 64'd3);
    tick();
    chk("rd_wait", 64'({mem_read, fsm_state}), 64'({1'b0, 3'd3}));
    mem_readdatavalid = 1'b1; mem_readdata = 512'hA; mem_response = 2'b00;
    tick();
    chk("rd_beat0", rd_data[63:0], 64'hA);
    mem_readdata = 512'hB; mem_response = 2'b10;
    tick();
    chk("rd_beat1", rd_data[63:0], 64'hB);
    chk("rd_err_count", 64'(mem_errors), 64'd1);
    chk("rd_err_status", 64'(rdwr_status[3:2]), 64'b01);
    mem_readdata = 512'hC; mem_response = 2'b00;
    tick();
    mem_readdatavalid = 1'b0;
    chk("rd_beat2", rd_data[63:0], 64'hC);
    chk("rd_done_state", 64'(fsm_state), 64'd4);
    chk("rd_done", 64'(rdwr_done), 64'b11);
    tick();
    chk("rd_ready", 64'(ready_for_sw_cmd), 64'd1);
    chk("rd_final_status", 64'(rdwr_status[3:2]), 64'b01);
    chk("rd_final_errors", 64'(mem_errors), 64'd1);
    mem_error_clr = 1'b1;
    tick();
    mem_error_clr = 1'b0;
    chk("err_clr", 64'(mem_errors), 64'd0);

    // Read that never returns data, burstcount 0 treated as 1
    pulse_rdwr_reset();
    cmd_read = 1'b1; cmd_address = 26'h400; cmd_burstcount = 7'd0;
    hit = 0;
    for (int i = 1; i <= 200 && hit == 0; i++) begin
      tick();
      if (i == 1) begin
        cmd_read = 1'b0;
        chk("to_bc_zero", 64'(mem_burstcount), 64'd1);
      end
      if (fsm_state == 3'd4) hit = i;
    end
    chk("to_cycle", 64'(hit), 64'(TO + 2));
    chk("to_status", 64'(rdwr_status), 64'b01000);
    chk("to_done", 64'(rdwr_done), 64'b10);
    tick();
    chk("to_idle", 64'({ready_for_sw_cmd, fsm_state}), 64'({1'b1, 3'd0}));
    mem_readdatavalid = 1'b1; mem_readdata = 512'hFF; mem_response = 2'b11;
    tick();
    mem_readdatavalid = 1'b0; mem_response = 2'b00;
    tick();
    chk("late_beat_data", rd_data[63:0], 64'hC);
    chk("late_beat_errors", 64'(mem_errors), 64'd0);

    // Both strobes rising together
    pulse_rdwr_reset();
    cmd_read = 1'b1; cmd_write = 1'b1;
    tick();
    cmd_read = 1'b0; cmd_write = 1'b0;
    chk("both_state", 64'({ready_for_sw_cmd, fsm_state}), 64'({1'b1, 3'd0}));
    chk("both_no_xfer", 64'({mem_write, mem_read}), 64'd0);
    chk("both_illegal", 64'(rdwr_status), 64'b10000);
    tick();
    pulse_rdwr_reset();
    chk("illegal_cleared", 64'(rdwr_status), 64'd0);

    // Write with a strobe during the burst and rdwr_reset racing completion
    cmd_write = 1'b1; cmd_address = 26'h500; cmd_burstcount = 7'd2;
    wcnt = 0; rcnt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      wcnt += int'(mem_write);
      rcnt += int'(mem_read);
      if (i == 1) begin cmd_write = 1'b0; cmd_read = 1'b1; end
      if (i == 2) begin
        chk("mid_strobe_illegal", 64'(rdwr_status[4]), 64'd1);
        rdwr_reset = 1'b1;
      end
      if (i == 3) begin
        rdwr_reset = 1'b0;
        cmd_read = 1'b0;
        chk("race_done_survives", 64'(rdwr_done), 64'b01);
        chk("race_status", 64'(rdwr_status), 64'd0);
      end
    end
    chk("mid_strobe_wr_beats", 64'(wcnt), 64'd2);
    chk("mid_strobe_no_read", 64'(rcnt), 64'd0);

    // Asynchronous reset during a stalled read request, strobe held across release
    mem_waitrequest = 1'b1;
    cmd_read = 1'b1; cmd_address = 26'h600; cmd_burstcount = 7'd4;
    tick();
    chk("ar_read_up", 64'(mem_read), 64'd1);
    SoftReset_n = 1'b0;
    #1;
    chk("ar_read_drop", 64'(mem_read), 64'd0);
    chk("ar_idle", 64'({ready_for_sw_cmd, fsm_state}), 64'({1'b1, 3'd0}));
    chk("ar_outputs", 64'({rdwr_done, rdwr_status, mem_address}), 64'd0);
    chk("ar_rd_data", rd_data[63:0], 64'd0);
    repeat (2) tick();
    SoftReset_n = 1'b1;
    repeat (3) tick();
    chk("held_strobe_ignored", 64'({mem_read, fsm_state}), 64'd0);
    cmd_read = 1'b0;
    tick();
    cmd_read = 1'b1;
    tick();
    cmd_read = 1'b0;
    chk("fresh_edge_accepted", 64'({mem_read, fsm_state}), 64'({1'b1, 3'd2}));
    chk("fresh_edge_addr", 64'(mem_address), 64'h600);
    mem_waitrequest = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_rdwr_fsm.md
# mem_rdwr_fsm

Command engine between the MMIO CSR block and one local-memory bank's Avalon-MM port. It takes the single-shot read/write command the CSR block issues (address, burst count, write data, byte enables) and runs it as a full Avalon burst, honoring waitrequest. It collects read beats and tracks response errors and timeouts. It returns done/status/state, the ready flag and the error count the CSR block exposes to software.

## Interface
- ADDR_W, 26, local-memory word address width
- DATA_W, 512, data width
- BURST_W, 7, burst-count width
- TIMEOUT, 1024, consecutive no-progress cycles before abort (≥2)
- clk  in  1  clock
- SoftReset_n  in  1  asynchronous, active-low reset
- cmd_read / cmd_write  in  1 each  command strobes from CSR (may be held >1 cycle)
- cmd_address  in  ADDR_W  burst start address
- cmd_burstcount  in  BURST_W  beats; 0 treated as 1
- cmd_writedata  in  DATA_W  data driven on every write beat
- cmd_byteenable  in  DATA_W/8  byte enables for every write beat
- rdwr_reset  in  1  clears rdwr_done and rdwr_status
- mem_error_clr  in  1  clears mem_errors
- ready_for_sw_cmd  out  1  high only in IDLE
- rdwr_done  out  2  [0] write done, [1] read done; sticky
- rdwr_status  out  5  [1:0] write status, [3:2] read status, [4] illegal command; sticky
- fsm_state  out  3  current state encoding
- mem_errors  out  32  saturating count of errored read beats
- rd_data  out  DATA_W  most recent read beat
- mem_address, mem_burstcount, mem_read, mem_write, mem_writedata, mem_byteenable  out  Avalon master request signals
- mem_waitrequest, mem_readdatavalid  in  1; mem_readdata  in  DATA_W; mem_response  in  2

## Operation
- States (fsm_state): IDLE=0, WR_BURST=1, RD_REQ=2, RD_WAIT=3, DONE=4.
- Strobes are registered; a command is accepted only on a rising edge (strobe high, previous-cycle strobe low) while in IDLE.
- Both rising edges in the same cycle: the command is rejected, status[4] is set, and the FSM stays IDLE.
- Rising edge outside IDLE: the command is dropped and status[4] is set.
- On accept, latch address, burst count (0→1), write data and byte enables, and load the beat counter.
- Write accepted → WR_BURST.
  - mem_write is held high with constant address/burstcount/data/byteenable.
  - A beat completes on each cycle with mem_write && !mem_waitrequest.
  - After the last beat: set rdwr_done[0], write status 00, go to DONE.
- Read accepted → RD_REQ.
  - mem_read is held until !mem_waitrequest, then → RD_WAIT.
  - Each mem_readdatavalid loads rd_data and decrements the remaining count.
  - A beat with mem_response≠0 sets read status to 01 and increments mem_errors.
  - After the last beat: set rdwr_done[1] and go to DONE; read status stays 00 if no beat errored.
- Timeout: a 16-bit stall counter increments on each WR_BURST/RD_REQ cycle with waitrequest high, and on each RD_WAIT cycle without readdatavalid. It clears on progress and on entry to a state.
  - When it reaches TIMEOUT: drop mem_read/mem_write, set the done bit, set status to 01 (write) or 10 (read), go to DONE.
  - Readdatavalid beats arriving after a timeout are ignored.
- DONE lasts one cycle, then IDLE.
- rdwr_done and rdwr_status are cleared by rdwr_reset. A set event in the same cycle wins.
- mem_errors saturates at 32'hFFFF_FFFF. mem_error_clr wins over an increment in the same cycle.

## Timing
- Reset values:
  - state IDLE, ready_for_sw_cmd=1.
  - mem_read=mem_write=0.
  - mem_address/burstcount/writedata/byteenable=0.
  - rdwr_done=0, rdwr_status=0, mem_errors=0, rd_data=0, fsm_state=0.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous); no completion is reported.
- Strobe rises at cycle T (sampled at edge T):
  - ready_for_sw_cmd is low from T+1.
  - mem_write/mem_read are high from T+1.
- Write, N beats, no waitrequest: beats at T+1..T+N; DONE and rdwr_done[0] visible at T+N+1; IDLE and ready at T+N+2.
- Read: the request is accepted at cycle A. If the last valid beat is at cycle L: rdwr_done[1] and DONE at L+1, ready at L+2. rd_data updates the cycle after each valid beat.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Write, burstcount 4, waitrequest low → mem_write high exactly 4 cycles, done=2'b01, status=0, ready again 6 cycles after strobe.
- Write, burstcount 2, waitrequest high for 3 cycles → 5 mem_write cycles, signals stable while stalled, done[0]=1.
- Read, burstcount 3, with readdatavalid beats 0xA,0xB,0xC and beat 2 response=2'b10 → rd_data=0xC, status[3:2]=01, mem_errors=1, done[1]=1; mem_error_clr → mem_errors=0.
- Read, never returning readdatavalid → abort after TIMEOUT cycles, status[3:2]=10, done[1]=1, back to IDLE; a late beat leaves rd_data unchanged.
- cmd_read and cmd_write rising together, then a new strobe during WR_BURST → status[4]=1, no extra transfer; rdwr_reset concurrent with write completion → done[0]=1 survives.
- SoftReset_n low mid-read-burst → mem_read=0, state IDLE, ready=1 immediately; a strobe held across reset release is not accepted unless a fresh rising edge occurs.
